// File: rtl/encoder_8_to_3_drain_if.sv
// Handshake bundle for encoder_8_to_3_drain: request vector in, index stream out.
// The slave modport is the encoder's view, the master modport is the view of
// the surrounding logic that supplies vectors and consumes indices.
interface encoder_8_to_3_drain_if #(
  parameter int W = 8
);
  localparam int IDX_W = $clog2(W);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out;
  logic             out_last;

  modport master (
    output in_valid,
    output in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out,
    output out_last
  );
endinterface

// File: rtl/encoder_8_to_3_drain.sv
// encoder_8_to_3_drain: takes a multi-hot request vector and drains it as a
// stream of binary indices, one per handshake, in priority order.
// Build option ENCODER_MSB_FIRST_EN: when defined the highest set bit goes
// first (descending indices); when undefined the lowest set bit goes first.
module encoder_8_to_3_drain #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  output logic                  busy,
  encoder_8_to_3_drain_if.slave bus
);
  localparam int IDX_W = $clog2(W);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t           state_q;
  logic [W-1:0]     pending_q;
  logic [IDX_W-1:0] out_q;
  logic             last_q;

  logic [W-1:0]     pend_rem_d;
  logic [IDX_W-1:0] out_rem_d;
  logic             last_rem_d;
  logic [IDX_W-1:0] out_load_d;
  logic             last_load_d;

  // Index of the bit that is emitted first from vector v (0 when v is empty).
  function automatic logic [IDX_W-1:0] prio_idx(input logic [W-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
`ifdef ENCODER_MSB_FIRST_EN
    for (int i = 0; i < W; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
`else
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
`endif
    return idx;
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic one_hot(input logic [W-1:0] v);
    return (v != '0) && ((v & (v - W'(1))) == '0);
  endfunction

  // Candidate register values for a fresh load and for the post-accept update.
  always_comb begin
    out_load_d  = prio_idx(bus.in);
    last_load_d = one_hot(bus.in);
    pend_rem_d  = pending_q & ~(W'(1) << out_q);
    out_rem_d   = prio_idx(pend_rem_d);
    last_rem_d  = one_hot(pend_rem_d);
  end

  // Control FSM with registered index/last outputs; everything holds while ena is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      out_q     <= '0;
      last_q    <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && (bus.in != '0)) begin
            pending_q <= bus.in;
            out_q     <= out_load_d;
            last_q    <= last_load_d;
            state_q   <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            pending_q <= pend_rem_d;
            out_q     <= out_rem_d;
            last_q    <= last_rem_d;
            if (last_q) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake strobes depend only on state, ena and rst; data comes straight from registers.
  always_comb begin
    bus.in_ready  = rst && ena && (state_q == IDLE);
    bus.out_valid = rst && ena && (state_q == DRAIN);
    bus.out       = out_q;
    bus.out_last  = last_q;
    busy          = (state_q == DRAIN);
  end
endmodule

// File: tb/tb_encoder_8_to_3_drain.sv
// Bench for encoder_8_to_3_drain: directed scenarios followed by a random
// phase, all checked against a queue-based model of the expected index stream.
module tb_encoder_8_to_3_drain;
  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic busy;

  always #5 clk = ~clk;

  encoder_8_to_3_drain_if #(.W(8)) bus ();

  encoder_8_to_3_drain #(.W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .busy (busy),
    .bus  (bus)
  );

  int unsigned ncmp  = 0;
  int unsigned nfail = 0;
  int          exp_q[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected index list of a vector: every set bit, in emission order.
  function automatic void load_model(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
`ifdef ENCODER_MSB_FIRST_EN
        exp_q.push_front(i);
`else
        exp_q.push_back(i);
`endif
      end
    end
  endfunction

  task automatic check_all();
    logic drain;
    drain = (exp_q.size() != 0);
    chk("busy", {7'd0, busy}, {7'd0, drain});
    chk("in_ready", {7'd0, bus.in_ready}, {7'd0, rst && ena && !drain});
    chk("out_valid", {7'd0, bus.out_valid}, {7'd0, rst && ena && drain});
    if (drain) begin
      chk("out", {5'd0, bus.out}, 8'(exp_q[0]));
      chk("out_last", {7'd0, bus.out_last}, {7'd0, exp_q.size() == 1});
    end
  endtask

  // One clock: update the model with the inputs seen at the edge, then check.
  task automatic step();
    @(posedge clk);
    if (!rst) begin
      exp_q.delete();
    end else if (ena) begin
      if (exp_q.size() != 0) begin
        if (bus.out_ready) void'(exp_q.pop_front());
      end else if (bus.in_valid && bus.in != 8'h00) begin
        load_model(bus.in);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [7:0] v);
    bus.in       = v;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst           = 1'b0;
    ena           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in        = 8'h00;
    bus.out_ready = 1'b0;
    @(negedge clk);
    steps(2);
    chk("reset_out", {5'd0, bus.out}, 8'h00);
    chk("reset_last", {7'd0, bus.out_last}, 8'h00);
    rst = 1'b1;
    step();

    // Vector with three set bits, consumer always ready.
    bus.out_ready = 1'b1;
    load(8'b1010_0100);
    steps(4);

    // Same vector with the consumer stalled for three cycles.
    bus.out_ready = 1'b0;
    load(8'b1010_0100);
    steps(3);
    bus.out_ready = 1'b1;
    steps(4);

    // Empty vector is dropped.
    load(8'h00);
    chk("zero_busy", {7'd0, busy}, 8'h00);
    chk("zero_ready", {7'd0, bus.in_ready}, 8'h01);
    steps(2);

    // Full vector.
    load(8'hFF);
    steps(9);

    // Reset in the middle of a drain, then a fresh one-bit load.
    load(8'h81);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_in_ready", {7'd0, bus.in_ready}, 8'h01);
    load(8'h10);
    chk("post_rst_out", {5'd0, bus.out}, 8'h04);
    chk("post_rst_last", {7'd0, bus.out_last}, 8'h01);
    steps(2);

    // Freeze with ena low while draining.
    load(8'h06);
    ena = 1'b0;
    steps(4);
    ena = 1'b1;
    steps(3);

    // Random phase.
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 1) == 1);
      bus.in        = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      ena           = ($urandom_range(0, 9) != 0);
      rst           = ($urandom_range(0, 49) != 0);
      step();
    end
    rst           = 1'b1;
    ena           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    steps(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
